// File: rtl/j_irq_pkg.sv
// Shared constants, index width helper and index type for the Jerry IRQ combiner.
package j_irq_pkg;

    localparam int unsigned J_IRQ_N_MAX = 32;

    // Width of a channel index for n channels (never narrower than 1 bit)
    function automatic int unsigned j_idx_w(input int unsigned n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

    typedef logic [j_idx_w(J_IRQ_N_MAX)-1:0] j_irq_idx_t;

endpackage

// File: rtl/j_irq_or_if.sv
// Request/mask/clear/ack bus between event sources, CPU side and j_irq_or.
interface j_irq_or_if
    import j_irq_pkg::*;
#(
    parameter int unsigned N = 16
);
    localparam int unsigned IDX_W = j_idx_w(N);

    logic [N-1:0]     req;
    logic             mask_wr;
    logic [N-1:0]     mask_din;
    logic             clr_wr;
    logic [N-1:0]     clr_din;
    logic             irq_ack;
    logic [N-1:0]     pend;
    logic [N-1:0]     mask;
    logic             irq;
    logic             sel_valid;
    logic [IDX_W-1:0] sel_idx;

    modport master (
        output req, mask_wr, mask_din, clr_wr, clr_din, irq_ack,
        input  pend, mask, irq, sel_valid, sel_idx
    );

    modport slave (
        input  req, mask_wr, mask_din, clr_wr, clr_din, irq_ack,
        output pend, mask, irq, sel_valid, sel_idx
    );

endinterface

// File: rtl/j_or_tree.sv
// Combinational OR reduction built from alternating nr4/nd4 stages.
// Input is zero-padded to 32 bits (a multiple of 4); zero groups give a
// neutral 1 at the nor stage and a neutral 0 at the nand stage.
module j_or_tree
    import j_irq_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] din,
    output logic         any_c
);

    logic [J_IRQ_N_MAX-1:0] pad_c;
    logic [7:0]             nr_c;
    logic [1:0]             nd_c;
    logic                   top_nr_c;

    // nr4 -> nd4 -> nr4 -> inv reduction of the padded vector
    always_comb begin
        pad_c        = '0;
        pad_c[W-1:0] = din;
        for (int g = 0; g < 8; g++) begin
            nr_c[g] = ~|pad_c[4*g +: 4];
        end
        for (int h = 0; h < 2; h++) begin
            nd_c[h] = ~&nr_c[4*h +: 4];
        end
        top_nr_c = ~|{2'b00, nd_c};
        any_c    = ~top_nr_c;
    end

endmodule

// File: rtl/j_irq_or.sv
// Registered N-channel interrupt combiner: sticky pending, mask, OR-reduced
// irq and lowest-index selection for acknowledge.
// Build option: JIRQ_EDGE_DETECT_EN selects rising-edge request capture;
// otherwise requests are level sensitive.
module j_irq_or
    import j_irq_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic      sys_clk,
    input  logic      resetl,
    j_irq_or_if.slave bus
);

    localparam int unsigned IDX_W = j_idx_w(N);

    logic [N-1:0]     set_c;
    logic [N-1:0]     ack_hot_c;
    logic [N-1:0]     clr_c;
    logic [N-1:0]     pend_next_c;
    logic [N-1:0]     active_c;
    logic             any_c;
    j_irq_idx_t       low_idx_c;

    logic [N-1:0]     pend_q;
    logic [N-1:0]     mask_q;
    logic             irq_q;
    logic             sel_valid_q;
    logic [IDX_W-1:0] sel_idx_q;

`ifdef JIRQ_EDGE_DETECT_EN
    logic [N-1:0] req_q;

    // Previous request levels, so a held request sets pending only once
    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            req_q <= '0;
        end else begin
            req_q <= bus.req;
        end
    end

    assign set_c = bus.req & ~req_q;
`else
    assign set_c = bus.req;
`endif

    // Ack clears the channel already registered on sel_idx, never a fresh pick
    always_comb begin
        ack_hot_c = '0;
        if (bus.irq_ack && sel_valid_q) begin
            ack_hot_c = N'(1) << sel_idx_q;
        end
    end

    assign clr_c       = ({N{bus.clr_wr}} & bus.clr_din) | ack_hot_c;
    assign pend_next_c = set_c | (pend_q & ~clr_c);
    assign active_c    = pend_q & mask_q;

    j_or_tree #(
        .W (N)
    ) u_or_tree (
        .din   (active_c),
        .any_c (any_c)
    );

    // Lowest set bit of masked pending; 0 when nothing is active
    always_comb begin
        low_idx_c = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (active_c[i]) begin
                low_idx_c = j_irq_idx_t'(i);
            end
        end
    end

    // Pending, mask and registered irq/selection state
    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            pend_q      <= '0;
            mask_q      <= '0;
            irq_q       <= 1'b0;
            sel_valid_q <= 1'b0;
            sel_idx_q   <= '0;
        end else begin
            pend_q      <= pend_next_c;
            if (bus.mask_wr) begin
                mask_q <= bus.mask_din;
            end
            irq_q       <= any_c;
            sel_valid_q <= any_c;
            sel_idx_q   <= IDX_W'(low_idx_c);
        end
    end

    assign bus.pend      = pend_q;
    assign bus.mask      = mask_q;
    assign bus.irq       = irq_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.sel_idx   = sel_idx_q;

endmodule

// File: tb/tb_j_irq_or.sv
// Directed self-checking bench for j_irq_or (N=16 main instance, N=2/5/32 sweep).
module tb_j_irq_or;

    logic sys_clk;
    logic resetl;
    int   checks;
    int   errors;

    j_irq_or_if #(.N(16)) b16 ();
    j_irq_or_if #(.N(2))  b2  ();
    j_irq_or_if #(.N(5))  b5  ();
    j_irq_or_if #(.N(32)) b32 ();

    j_irq_or #(.N(16)) u_dut16 (.sys_clk(sys_clk), .resetl(resetl), .bus(b16));
    j_irq_or #(.N(2))  u_dut2  (.sys_clk(sys_clk), .resetl(resetl), .bus(b2));
    j_irq_or #(.N(5))  u_dut5  (.sys_clk(sys_clk), .resetl(resetl), .bus(b5));
    j_irq_or #(.N(32)) u_dut32 (.sys_clk(sys_clk), .resetl(resetl), .bus(b32));

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Advance one rising edge and settle before driving/sampling
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetl = 1'b0;
        b16.req = '0; b16.mask_wr = 1'b0; b16.mask_din = '0;
        b16.clr_wr = 1'b0; b16.clr_din = '0; b16.irq_ack = 1'b0;
        b2.req = '0; b2.mask_wr = 1'b0; b2.mask_din = '0;
        b2.clr_wr = 1'b0; b2.clr_din = '0; b2.irq_ack = 1'b0;
        b5.req = '0; b5.mask_wr = 1'b0; b5.mask_din = '0;
        b5.clr_wr = 1'b0; b5.clr_din = '0; b5.irq_ack = 1'b0;
        b32.req = '0; b32.mask_wr = 1'b0; b32.mask_din = '0;
        b32.clr_wr = 1'b0; b32.clr_din = '0; b32.irq_ack = 1'b0;
        #2;
        tick();
        tick();

        // Reset values
        check("rst_pend", 64'(b16.pend), 64'h0);
        check("rst_mask", 64'(b16.mask), 64'h0);
        check("rst_irq", 64'(b16.irq), 64'h0);
        check("rst_sel_valid", 64'(b16.sel_valid), 64'h0);
        check("rst_sel_idx", 64'(b16.sel_idx), 64'h0);
        resetl = 1'b1;

        // 1. Reset mid-operation
        b16.mask_wr = 1'b1; b16.mask_din = 16'hFFFF; b16.req = 16'h00FF;
        tick();
        b16.mask_wr = 1'b0; b16.req = 16'h0000;
        tick();
        check("t1_pend_pre", 64'(b16.pend), 64'h00FF);
        check("t1_irq_pre", 64'(b16.irq), 64'h1);
        resetl = 1'b0;
        tick();
        check("t1_pend_rst", 64'(b16.pend), 64'h0);
        check("t1_mask_rst", 64'(b16.mask), 64'h0);
        check("t1_irq_rst", 64'(b16.irq), 64'h0);
        check("t1_valid_rst", 64'(b16.sel_valid), 64'h0);
        resetl = 1'b1;
        tick();
        tick();
        check("t1_irq_after", 64'(b16.irq), 64'h0);
        check("t1_pend_after", 64'(b16.pend), 64'h0);

        // 2. Mask gating: masked channel still pends, irq follows unmask by one cycle
        b16.req = 16'h0020;
        tick();
        b16.req = 16'h0000;
        tick();
        check("t2_pend", 64'(b16.pend), 64'h0020);
        check("t2_irq_masked", 64'(b16.irq), 64'h0);
        b16.mask_wr = 1'b1; b16.mask_din = 16'h0020;
        tick();
        b16.mask_wr = 1'b0;
        check("t2_mask", 64'(b16.mask), 64'h0020);
        check("t2_irq_same_edge", 64'(b16.irq), 64'h0);
        tick();
        check("t2_irq", 64'(b16.irq), 64'h1);
        check("t2_sel_idx", 64'(b16.sel_idx), 64'h5);

        // 3. Priority and acknowledge walk
        b16.clr_wr = 1'b1; b16.clr_din = 16'hFFFF;
        b16.mask_wr = 1'b1; b16.mask_din = 16'hFFFF;
        tick();
        b16.clr_wr = 1'b0; b16.mask_wr = 1'b0;
        b16.req = 16'h4208;
        tick();
        b16.req = 16'h0000;
        tick();
        check("t3_pend", 64'(b16.pend), 64'h4208);
        check("t3_sel3", 64'(b16.sel_idx), 64'd3);
        check("t3_valid", 64'(b16.sel_valid), 64'h1);
        b16.irq_ack = 1'b1;
        tick();
        b16.irq_ack = 1'b0;
        tick();
        check("t3_pend_ack1", 64'(b16.pend), 64'h4200);
        check("t3_sel9", 64'(b16.sel_idx), 64'd9);
        b16.irq_ack = 1'b1;
        tick();
        b16.irq_ack = 1'b0;
        tick();
        check("t3_sel14", 64'(b16.sel_idx), 64'd14);
        b16.irq_ack = 1'b1;
        tick();
        b16.irq_ack = 1'b0;
        tick();
        check("t3_valid_end", 64'(b16.sel_valid), 64'h0);
        check("t3_irq_end", 64'(b16.irq), 64'h0);
        check("t3_sel_end", 64'(b16.sel_idx), 64'h0);

        // Ack while sel_valid=0 must not touch channel 0
        b16.mask_wr = 1'b1; b16.mask_din = 16'h0000; b16.req = 16'h0001;
        tick();
        b16.mask_wr = 1'b0; b16.req = 16'h0000; b16.irq_ack = 1'b1;
        tick();
        b16.irq_ack = 1'b0;
        tick();
        check("t3_ack_ignored_pend", 64'(b16.pend), 64'h0001);
        check("t3_ack_ignored_valid", 64'(b16.sel_valid), 64'h0);

        // 4. Set beats a same-cycle clear
        b16.req = 16'h0004;
        tick();
        b16.req = 16'h0000;
        tick();
        check("t4_pend_pre", 64'(b16.pend), 64'h0005);
        b16.clr_wr = 1'b1; b16.clr_din = 16'h0004; b16.req = 16'h0004;
        tick();
        b16.clr_wr = 1'b0; b16.req = 16'h0000;
        check("t4_collision", 64'(b16.pend), 64'h0005);
        tick();
        b16.clr_wr = 1'b1; b16.clr_din = 16'h0005;
        tick();
        b16.clr_wr = 1'b0;
        check("t4_clear", 64'(b16.pend), 64'h0000);

        // 5. Held request, cleared at cycle 4
        b16.req = 16'h0080;
        tick();
        tick();
        tick();
        b16.clr_wr = 1'b1; b16.clr_din = 16'h0080;
        tick();
        b16.clr_wr = 1'b0;
        tick();
`ifdef JIRQ_EDGE_DETECT_EN
        check("t5_pend7_c5", 64'(b16.pend), 64'h0000);
`else
        check("t5_pend7_c5", 64'(b16.pend), 64'h0080);
`endif
        for (int c = 6; c <= 10; c++) begin
            tick();
        end
`ifdef JIRQ_EDGE_DETECT_EN
        check("t5_pend7_c10", 64'(b16.pend), 64'h0000);
`else
        check("t5_pend7_c10", 64'(b16.pend), 64'h0080);
`endif
        b16.req = 16'h0000;
        tick();
        b16.clr_wr = 1'b1; b16.clr_din = 16'hFFFF;
        tick();
        b16.clr_wr = 1'b0;
        tick();
        check("t5_cleanup", 64'(b16.pend), 64'h0000);

        // 6. Width sweep: one request per channel, irq exactly two edges later
        b2.mask_wr = 1'b1; b2.mask_din = '1;
        b5.mask_wr = 1'b1; b5.mask_din = '1;
        b32.mask_wr = 1'b1; b32.mask_din = '1;
        tick();
        b2.mask_wr = 1'b0; b5.mask_wr = 1'b0; b32.mask_wr = 1'b0;

        for (int ch = 0; ch < 2; ch++) begin
            b2.req = 2'd1 << ch;
            tick();
            b2.req = '0;
            check("n2_irq_t1", 64'(b2.irq), 64'h0);
            tick();
            check("n2_irq_t2", 64'(b2.irq), 64'h1);
            check("n2_sel", 64'(b2.sel_idx), 64'(ch));
            b2.clr_wr = 1'b1; b2.clr_din = '1;
            tick();
            b2.clr_wr = 1'b0;
            tick();
            check("n2_irq_clr", 64'(b2.irq), 64'h0);
        end

        for (int ch = 0; ch < 5; ch++) begin
            b5.req = 5'd1 << ch;
            tick();
            b5.req = '0;
            check("n5_irq_t1", 64'(b5.irq), 64'h0);
            tick();
            check("n5_irq_t2", 64'(b5.irq), 64'h1);
            check("n5_sel", 64'(b5.sel_idx), 64'(ch));
            b5.clr_wr = 1'b1; b5.clr_din = '1;
            tick();
            b5.clr_wr = 1'b0;
            tick();
            check("n5_irq_clr", 64'(b5.irq), 64'h0);
        end

        for (int ch = 0; ch < 32; ch++) begin
            b32.req = 32'd1 << ch;
            tick();
            b32.req = '0;
            check("n32_irq_t1", 64'(b32.irq), 64'h0);
            tick();
            check("n32_irq_t2", 64'(b32.irq), 64'h1);
            check("n32_sel", 64'(b32.sel_idx), 64'(ch));
            b32.clr_wr = 1'b1; b32.clr_din = '1;
            tick();
            b32.clr_wr = 1'b0;
            tick();
            check("n32_irq_clr", 64'(b32.irq), 64'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
